// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front-end and its consumers.
// Debounce FSM state encoding plus the default debounce interval.
package btn_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 20 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE = 1000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter and FSM,
// registered level plus single-cycle press/release pulses.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic             sync1_q;
    logic             sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= pin_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Pulses default low so they can never persist past one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                level_d = 1'b0;
                if (sync2_q) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESSED: begin
                level_d = 1'b1;
                if (!sync2_q) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = S_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// East/west push-button front-end: two independent debounce channels
// producing clean levels and press/release pulses for the LED counter.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_east,
    input  logic btn_west,
    output logic east_level,
    output logic west_level,
    output logic east_press,
    output logic west_press,
    output logic east_release,
    output logic west_release
);

    btn_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_east (
        .clk       (clk),
        .reset     (reset),
        .pin_i     (btn_east),
        .level_o   (east_level),
        .press_o   (east_press),
        .release_o (east_release)
    );

    btn_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_west (
        .clk       (clk),
        .reset     (reset),
        .pin_i     (btn_west),
        .level_o   (west_level),
        .press_o   (west_press),
        .release_o (west_release)
    );

endmodule
